// File: rtl/dsp_post_adder_acc.sv
// Post-adder / accumulator stage of a DSP48A1-style slice.
// Selects X and Z operands by opmode, adds or subtracts them with carry-in,
// and registers the result in P. P is fed back internally for accumulation.
// Optional pipeline registers (C, opmode/carryin, P) are always present; the
// CREG / OPMODEREG / PREG parameters pick the registered or direct value.
//
// Optional feature: define DSP_ACC_OVERFLOW_EN to add a sticky signed-overflow
// flag output (ovf).
//
// Ports:
//   clk       clock
//   rst       asynchronous active-high reset of all internal registers
//   M         36-bit unsigned product from the M stage
//   DAB       48-bit {D[11:0],A[17:0],B[17:0]}
//   C         48-bit C operand
//   PCIN      48-bit cascade input
//   opmode    [1:0] X select, [3:2] Z select, [4] subtract
//   carryin   carry-in
//   CEC       C register enable
//   CEOP      opmode/carryin register enable
//   CEP       P/CARRYOUT register enable
//   P         result
//   PCOUT     cascade output, identical to P
//   CARRYOUT  bit 48 of the 49-bit sum/difference
//   ovf       sticky signed overflow flag (DSP_ACC_OVERFLOW_EN only)
module dsp_post_adder_acc #(
  parameter int CREG      = 1,
  parameter int OPMODEREG = 1,
  parameter int PREG      = 1,
  parameter int WIDTH_P   = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [35:0]        M,
  input  logic [WIDTH_P-1:0] DAB,
  input  logic [WIDTH_P-1:0] C,
  input  logic [WIDTH_P-1:0] PCIN,
  input  logic [4:0]         opmode,
  input  logic               carryin,
  input  logic               CEC,
  input  logic               CEOP,
  input  logic               CEP,
  output logic [WIDTH_P-1:0] P,
  output logic [WIDTH_P-1:0] PCOUT,
  output logic               CARRYOUT
`ifdef DSP_ACC_OVERFLOW_EN
  ,
  output logic               ovf
`endif
);

  localparam int unsigned WM = 36;
  localparam int unsigned WO = 5;
  localparam int unsigned WS = WIDTH_P + 1;

  logic [WIDTH_P-1:0] c_r;
  logic [WO-1:0]      op_r;
  logic               cin_r;
  logic [WIDTH_P-1:0] p_r;
  logic               cy_r;

  logic [WIDTH_P-1:0] c_eff;
  logic [WO-1:0]      op_eff;
  logic               cin_eff;
  logic [WIDTH_P-1:0] x;
  logic [WIDTH_P-1:0] z;
  logic [WS-1:0]      s;

  // Pipeline registers; each loads only when its own enable is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_r   <= '0;
      op_r  <= '0;
      cin_r <= 1'b0;
      p_r   <= '0;
      cy_r  <= 1'b0;
    end else begin
      if (CEC) c_r <= C;
      if (CEOP) begin
        op_r  <= opmode;
        cin_r <= carryin;
      end
      if (CEP) begin
        p_r  <= s[WIDTH_P-1:0];
        cy_r <= s[WIDTH_P];
      end
    end
  end

  // Operand selection and 49-bit add/subtract. Feedback always uses p_r so
  // PREG=0 never closes a combinational loop.
  always_comb begin
    c_eff   = (CREG != 0) ? c_r : C;
    op_eff  = (OPMODEREG != 0) ? op_r : opmode;
    cin_eff = (OPMODEREG != 0) ? cin_r : carryin;
    x       = '0;
    z       = '0;
    case (op_eff[1:0])
      2'd0:    x = '0;
      2'd1:    x = {{(WIDTH_P - WM){1'b0}}, M};
      2'd2:    x = p_r;
      default: x = DAB;
    endcase
    case (op_eff[3:2])
      2'd0:    z = '0;
      2'd1:    z = PCIN;
      2'd2:    z = p_r;
      default: z = c_eff;
    endcase
    // Bit 48 is the carry on add and the borrow on subtract.
    if (op_eff[4]) s = {1'b0, z} - ({1'b0, x} + WS'(cin_eff));
    else           s = {1'b0, z} + {1'b0, x} + WS'(cin_eff);
  end

  assign P        = (PREG != 0) ? p_r  : s[WIDTH_P-1:0];
  assign PCOUT    = P;
  assign CARRYOUT = (PREG != 0) ? cy_r : s[WIDTH_P];

`ifdef DSP_ACC_OVERFLOW_EN
  logic ovf_c;

  // Signed overflow of the update that P_r would capture this cycle.
  always_comb begin
    ovf_c = 1'b0;
    if (op_eff[4])
      ovf_c = (x[WIDTH_P-1] != z[WIDTH_P-1]) && (s[WIDTH_P-1] != z[WIDTH_P-1]);
    else
      ovf_c = (x[WIDTH_P-1] == z[WIDTH_P-1]) && (s[WIDTH_P-1] != z[WIDTH_P-1]);
  end

  // Sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               ovf <= 1'b0;
    else if (CEP && ovf_c) ovf <= 1'b1;
  end
`endif

endmodule
